// File: rtl/lfsr_stream.sv
// Galois LFSR word generator: STEP single-bit shifts per advance, with a
// ready/valid output stage, state load, zero-load recovery and wrap detection.
module lfsr_stream #(
    parameter int unsigned    LEN  = 8,
    parameter logic [LEN-1:0] TAPS = 8'b10111000,
    parameter logic [LEN-1:0] SEED = {LEN{1'b1}},
    parameter int unsigned    STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic [LEN-1:0]  load_val,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [STEP-1:0] out_data,
    output logic [LEN-1:0]  sreg,
    output logic            lockup,
    output logic            wrapped
);

    if (LEN < 2 || LEN > 64) begin : g_bad_len
        $fatal(1, "lfsr_stream: LEN must be in 2..64");
    end
    if (STEP < 1 || STEP > LEN) begin : g_bad_step
        $fatal(1, "lfsr_stream: STEP must be in 1..LEN");
    end
    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr_stream: SEED must be non-zero");
    end

    logic [LEN-1:0]  sreg_q, sreg_d;
    logic [STEP-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            lockup_q, lockup_d;
    logic            wrapped_q, wrapped_d;

    logic [LEN-1:0]  step_state;
    logic [STEP-1:0] step_bits;
    logic            advance;

    // Unrolled STEP single shifts; bit i is the LSB seen before shift i+1.
    always_comb begin
        step_state = sreg_q;
        step_bits  = '0;
        for (int unsigned i = 0; i < STEP; i++) begin
            step_bits[i] = step_state[0];
            step_state   = {1'b0, step_state[LEN-1:1]} ^ (step_state[0] ? TAPS : '0);
        end
    end

    assign advance = en && !load && (!valid_q || out_ready);

    always_comb begin
        sreg_d    = sreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        lockup_d  = 1'b0;
        wrapped_d = 1'b0;
        if (load) begin
            valid_d = 1'b0;
            if (load_val == '0) begin
                sreg_d   = SEED;
                lockup_d = 1'b1;
            end else begin
                sreg_d = load_val;
            end
        end else if (advance) begin
            sreg_d    = step_state;
            data_d    = step_bits;
            valid_d   = 1'b1;
            wrapped_d = (step_state == SEED);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q    <= SEED;
            data_q    <= '0;
            valid_q   <= 1'b0;
            lockup_q  <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            lockup_q  <= lockup_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign sreg      = sreg_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign lockup    = lockup_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboarded random and directed bench for lfsr_stream (defaults plus a STEP=8 instance).
module tb_lfsr_stream;

    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'hFF;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, load = 1'b0, out_ready = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       out_valid, lockup, wrapped;
    logic [0:0] out_data;
    logic [7:0] sreg;

    logic       en8 = 1'b0;
    logic       out_valid8, lockup8, wrapped8;
    logic [7:0] out_data8, sreg8;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_s = SEED;
    logic       m_valid = 1'b0;
    logic       m_data = 1'b0;

    logic [10:0] state_q[$];  // {sreg, valid, lockup, wrapped} after an edge
    logic [8:0]  word_q[$];   // {data, sreg} for each word produced

    lfsr_stream u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sreg(sreg), .lockup(lockup), .wrapped(wrapped)
    );

    lfsr_stream #(.STEP(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .load(1'b0), .load_val(8'h00),
        .out_ready(1'b1), .out_valid(out_valid8), .out_data(out_data8),
        .sreg(sreg8), .lockup(lockup8), .wrapped(wrapped8)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] g1(input logic [7:0] s);
        logic [7:0] r;
        r = 8'(s / 2);
        if (s % 2 == 1) r = r ^ TAPS;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model predicts the post-edge state.
    task automatic cycle(input bit r, input bit e, input bit l, input logic [7:0] lv,
                         input bit rdy);
        bit e_lock, e_wrap, push_w;
        rst = r; en = e; load = l; load_val = lv; out_ready = rdy;
        e_lock = 0; e_wrap = 0; push_w = 0;
        if (r) begin
            m_s = SEED; m_valid = 0; m_data = 0;
        end else if (l) begin
            m_valid = 0;
            if (lv == 0) begin m_s = SEED; e_lock = 1; end
            else m_s = lv;
        end else if (e && (!m_valid || rdy)) begin
            m_data = m_s[0];
            m_s = g1(m_s);
            m_valid = 1; e_wrap = (m_s == SEED); push_w = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
        state_q.push_back({m_s, m_valid, e_lock, e_wrap});
        if (push_w) word_q.push_back({m_data, m_s});
    endtask

    // Monitor: per-cycle state, plus the presented word while out_valid.
    always @(negedge clk) begin
        logic [10:0] st;
        logic [8:0]  w;
        if (state_q.size() > 0) begin
            st = state_q.pop_front();
            chk("sreg", 64'(sreg), 64'(st[10:3]));
            chk("out_valid", 64'(out_valid), 64'(st[2]));
            chk("lockup", 64'(lockup), 64'(st[1]));
            chk("wrapped", 64'(wrapped), 64'(st[0]));
        end
        if (out_valid) begin
            if (word_q.size() == 0) begin
                chk("word_expected", 64'(out_valid), 64'(0));
            end else begin
                w = word_q[0];
                chk("out_data", 64'(out_data), 64'(w[8]));
                chk("word_sreg", 64'(sreg), 64'(w[7:0]));
                if (rst || load || out_ready) void'(word_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] seq[0:320];
        logic [7:0] exp8;
        int wraps, zeros;

        // Reset dominates a simultaneous load of zero and enable.
        cycle(1, 1, 1, 8'h00, 1);
        cycle(1, 1, 1, 8'h00, 1);
        chk("rst_sreg", 64'(sreg), 64'hFF);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_lockup", 64'(lockup), 64'(0));

        cycle(0, 1, 0, 8'h00, 1);
        chk("first_sreg", 64'(sreg), 64'hC7);
        chk("first_data", 64'(out_data), 64'(1));
        cycle(0, 1, 0, 8'h00, 1);
        chk("second_sreg", 64'(sreg), 64'hDB);
        chk("second_data", 64'(out_data), 64'(1));

        // Continuous run: period 255 from the seed (two advances already done).
        wraps = 0; zeros = 0;
        for (int i = 0; i < 508; i++) begin
            cycle(0, 1, 0, 8'h00, 1);
            if (wrapped) wraps++;
            if (sreg == 8'h00) zeros++;
        end
        chk("wrap_count", 64'(wraps), 64'(2));
        chk("zero_states", 64'(zeros), 64'(0));

        // Backpressure hold, then one consumed and the next delivered.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'h00, 0);
        cycle(0, 1, 0, 8'h00, 1);
        cycle(0, 1, 0, 8'h00, 0);

        // Zero load during backpressure recovers to SEED; non-zero load does not pulse.
        cycle(0, 1, 1, 8'h00, 0);
        chk("zload_sreg", 64'(sreg), 64'hFF);
        chk("zload_lockup", 64'(lockup), 64'(1));
        cycle(0, 0, 1, 8'h5A, 0);
        chk("load_sreg", 64'(sreg), 64'h5A);
        chk("load_lockup", 64'(lockup), 64'(0));
        cycle(0, 1, 0, 8'h00, 1);

        // STEP=8 instance against 8 single steps per advance.
        seq[0] = SEED;
        for (int i = 1; i <= 320; i++) seq[i] = g1(seq[i-1]);
        en8 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycle(0, 0, 0, 8'h00, 0);
            for (int i = 0; i < 8; i++) exp8[i] = seq[8*(k-1)+i][0];
            chk("step8_sreg", 64'(sreg8), 64'(seq[8*k]));
            chk("step8_data", 64'(out_data8), 64'(exp8));
            chk("step8_valid", 64'(out_valid8), 64'(1));
        end
        en8 = 1'b0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, l;
            logic [7:0] lv;
            r  = ($urandom_range(63) == 0);
            l  = ($urandom_range(15) == 0);
            lv = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
            cycle(r, $urandom_range(3) != 0, l, lv, $urandom_range(3) != 0);
        end
        cycle(0, 0, 0, 8'h00, 1);
        cycle(0, 0, 0, 8'h00, 0);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_stream.md
LFSR_STREAM -- requirements
Module: lfsr_stream

Interface
REQ-001 The module SHALL take parameter LEN, default 8: shift-register length in bits, range 2..64.
REQ-002 The module SHALL take parameter TAPS, default 8'b10111000: Galois XOR tap mask, LEN bits wide.
REQ-003 The module SHALL take parameter SEED, default {LEN{1'b1}}: reset and recovery state, which SHALL be non-zero.
REQ-004 The module SHALL take parameter STEP, default 1: single-bit shifts per advance, range 1..LEN.
REQ-005 The module SHALL fail elaboration when SEED == 0, or when STEP or LEN is outside its range.
REQ-006 clk  input  1  clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 en  input  1  generation enable.
REQ-009 load  input  1  load a new state from load_val.
REQ-010 load_val  input  LEN  state value to load.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_valid  output  1  out_data holds an unconsumed word.
REQ-013 out_data  output  STEP  bits shifted out by the last advance.
REQ-014 sreg  output  LEN  current register state.
REQ-015 lockup  output  1  one-cycle pulse: a zero load was replaced by SEED.
REQ-016 wrapped  output  1  one-cycle pulse: an advance landed sreg on SEED.

Function
REQ-017 The single step g(s) SHALL be defined as {1'b0, s[LEN-1:1]} XOR (s[0] ? TAPS : 0).
REQ-018 An advance SHALL apply g exactly STEP times in one cycle, combinationally and without extra latency.
REQ-019 On an advance, out_data[i] SHALL equal s[0] before the (i+1)-th single step, for i = 0..STEP-1.
REQ-020 An advance SHALL occur when en && !load && (!out_valid || out_ready).
REQ-021 On an advance, the next state SHALL be sreg <= g^STEP(sreg), out_data <= the shifted bits, and out_valid <= 1.
REQ-022 When out_valid && !out_ready, sreg, out_data and out_valid SHALL hold unchanged regardless of en.
REQ-023 When out_valid && out_ready && !en && !load, out_valid SHALL fall to 0 and sreg and out_data SHALL hold.
REQ-024 When !out_valid && !en, all state SHALL hold.
REQ-025 load SHALL override the advance and backpressure: sreg <= load_val, out_valid <= 0 (pending word discarded), out_data holds.
REQ-026 If load_val == 0 on a load, the module SHALL set sreg <= SEED and pulse lockup for exactly the next cycle.
REQ-027 wrapped SHALL be 1 for exactly the cycle after an advance whose resulting sreg == SEED, and 0 otherwise; a load never sets it.
REQ-028 Output latency SHALL be one cycle: a word advanced at edge N SHALL be visible on out_data/out_valid after edge N.
REQ-029 Throughput SHALL be one word per cycle while en && out_ready are held high.

Reset
REQ-030 rst SHALL override load and en; on reset, sreg <= SEED, out_valid <= 0, out_data <= 0, lockup <= 0, wrapped <= 0.
REQ-031 Reset asserted mid-stream SHALL discard any pending word; the first advance after reset SHALL start from SEED.

Verification
REQ-032 Defaults, reset, then en=1 and out_ready=1 -> after the first advance sreg=0xC7, out_data=1, out_valid=1; after the second advance sreg=0xDB, out_data=1.
REQ-033 Defaults, continuous advance -> wrapped pulses exactly once every 255 advances; sreg is never 0x00.
REQ-034 STEP=8, same seed and taps -> sreg after k advances equals the STEP=1 sreg after 8k advances, and out_data equals those 8 shifted bits, LSB first.
REQ-035 out_valid=1, then out_ready=0 for 5 cycles with en=1 -> sreg and out_data stable; out_ready=1 -> one word consumed and the next word delivered the following cycle.
REQ-036 load=1 with load_val=0x00 during backpressure -> sreg=0xFF, out_valid=0, one-cycle lockup pulse; load_val=0x5A -> sreg=0x5A and no lockup pulse.
REQ-037 rst together with load=1 and en=1 -> sreg=0xFF, out_valid=0, lockup=0, wrapped=0.
